conv_window_gen: RTL and testbench

Streaming 3x3 window generator that feeds the 3x3 convolution datapath. It accepts one 16-bit pixel per cycle in raster order and keeps two line buffers plus a 3x3 register window. It presents the nine pixels of each fully-populated window on `win0`..`win8`, which map to the convolution's `in0`..`in8`. Convolution is valid-only (no padding), so each IMG_W x IMG_H frame yields (IMG_W-2) x (IMG_H-2) windows.

---
 rtl/cnn_pkg.sv | 8 +
 rtl/line_buffer.sv | 29 ++
 rtl/conv_window_gen.sv | 115 +++++++++++
 tb/tb_conv_window_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the 3x3 convolution front end: pixel type and kernel geometry.
package cnn_pkg;
    localparam int DATA_W = 16;
    localparam int KSIZE  = 3;
    localparam int WIN_N  = KSIZE * KSIZE;

    typedef logic [DATA_W-1:0] pix_t;
endpackage

// File: rtl/line_buffer.sv
// Enable-gated delay line: dout is din delayed by DEPTH enabled cycles (read before write).
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    // Pure data storage; contents before the first full row are masked by the counters.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];
endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers, a 3x3 register window and
// row/col counters that flag valid (no-padding) windows and the end of frame.
module conv_window_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic              win_valid,
    output logic [DATA_W-1:0] win0,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic [DATA_W-1:0] win3,
    output logic [DATA_W-1:0] win4,
    output logic [DATA_W-1:0] win5,
    output logic [DATA_W-1:0] win6,
    output logic [DATA_W-1:0] win7,
    output logic [DATA_W-1:0] win8,
    output logic              frame_done
);
    import cnn_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [WIN_N-1:0][DATA_W-1:0] win_q, win_d;
    logic win_valid_q, win_valid_d;
    logic frame_done_q, frame_done_d;

    logic              accept;
    logic              last_col, last_row;
    logic [DATA_W-1:0] lb0_out, lb1_out;

    assign accept   = pix_valid & ~clear;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
        .clk  (clk),
        .en   (accept),
        .din  (pix_in),
        .dout (lb0_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk  (clk),
        .en   (accept),
        .din  (lb0_out),
        .dout (lb1_out)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (pix_valid) begin
            // Validity uses the counters of the pixel being accepted, before they advance.
            win_valid_d  = (row_q >= RW'(2)) && (col_q >= CW'(2));
            frame_done_d = last_row && last_col;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win_d[r*KSIZE + c] = win_q[r*KSIZE + c + 1];
                end
            end
            win_d[KSIZE-1]       = lb1_out;
            win_d[2*KSIZE-1]     = lb0_out;
            win_d[KSIZE*KSIZE-1] = pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign win0 = win_q[0];
    assign win1 = win_q[1];
    assign win2 = win_q[2];
    assign win3 = win_q[3];
    assign win4 = win_q[4];
    assign win5 = win_q[5];
    assign win6 = win_q[6];
    assign win7 = win_q[7];
    assign win8 = win_q[8];
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 4x4 table-driven frames plus a 28x28 random frame.
module tb_conv_window_gen;
    typedef logic [8:0][15:0] win_t;
    typedef struct {
        logic        v;
        logic        clr;
        logic [15:0] pix;
        logic        ev;
        logic        ed;
        win_t        ew;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic s_clr = 1'b0, s_pv = 1'b0;
    logic [15:0] s_pix = '0;
    logic s_wv, s_fd;
    logic [15:0] s_w0, s_w1, s_w2, s_w3, s_w4, s_w5, s_w6, s_w7, s_w8;
    win_t s_win;
    assign s_win = {s_w8, s_w7, s_w6, s_w5, s_w4, s_w3, s_w2, s_w1, s_w0};

    logic b_clr = 1'b0, b_pv = 1'b0;
    logic [15:0] b_pix = '0;
    logic b_wv, b_fd;
    logic [15:0] b_w0, b_w1, b_w2, b_w3, b_w4, b_w5, b_w6, b_w7, b_w8;
    win_t b_win;
    assign b_win = {b_w8, b_w7, b_w6, b_w5, b_w4, b_w3, b_w2, b_w1, b_w0};

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .clear(s_clr), .pix_valid(s_pv), .pix_in(s_pix),
        .win_valid(s_wv), .win0(s_w0), .win1(s_w1), .win2(s_w2), .win3(s_w3),
        .win4(s_w4), .win5(s_w5), .win6(s_w6), .win7(s_w7), .win8(s_w8),
        .frame_done(s_fd)
    );

    conv_window_gen #(.IMG_W(28), .IMG_H(28), .DATA_W(16)) u_big (
        .clk(clk), .rst_n(rst_n), .clear(b_clr), .pix_valid(b_pv), .pix_in(b_pix),
        .win_valid(b_wv), .win0(b_w0), .win1(b_w1), .win2(b_w2), .win3(b_w3),
        .win4(b_w4), .win5(b_w5), .win6(b_w6), .win7(b_w7), .win8(b_w8),
        .frame_done(b_fd)
    );

    int   tests = 0;
    int   fails = 0;
    vec_t tbl[$];

    task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Window for pixel (r,c) of a 4x4 frame whose pixel values are base + 4*row + col.
    function automatic win_t win_of(input int base, input int r, input int c);
        win_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i*3 + j] = 16'(base + (r - 2 + i) * 4 + (c - 2 + j));
        return w;
    endfunction

    function automatic win_t mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        win_t w;
        w[0] = 16'(a0); w[1] = 16'(a1); w[2] = 16'(a2);
        w[3] = 16'(a3); w[4] = 16'(a4); w[5] = 16'(a5);
        w[6] = 16'(a6); w[7] = 16'(a7); w[8] = 16'(a8);
        return w;
    endfunction

    task automatic add(input logic v, input logic clr, input int pix,
                       input logic ev, input logic ed, input win_t ew);
        vec_t e;
        e.v = v; e.clr = clr; e.pix = 16'(pix); e.ev = ev; e.ed = ed; e.ew = ew;
        tbl.push_back(e);
    endtask

    task automatic add_frame(input int base, input bit gaps);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                logic ev;
                ev = (r >= 2) && (c >= 2);
                add(1'b1, 1'b0, base + r*4 + c, ev, (r == 3) && (c == 3),
                    ev ? win_of(base, r, c) : win_t'('0));
                if (gaps) add(1'b0, 1'b0, 16'hdead, 1'b0, 1'b0, '0);
            end
        end
    endtask

    task automatic push_s(input logic v, input logic clr, input logic [15:0] p);
        @(negedge clk);
        s_pv = v; s_clr = clr; s_pix = p;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl(input string name, input int exp_wins);
        int nw = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            push_s(tbl[i].v, tbl[i].clr, tbl[i].pix);
            check({name, "_valid"}, s_wv, tbl[i].ev);
            check({name, "_done"}, s_fd, tbl[i].ed);
            if (tbl[i].ev) check({name, "_win"}, s_win, tbl[i].ew);
            if (s_wv) nw++;
        end
        @(negedge clk);
        s_pv = 1'b0; s_clr = 1'b0;
        check({name, "_count"}, nw, exp_wins);
        tbl.delete();
    endtask

    logic [15:0] img[28][28];

    initial begin
        // Reset state
        #12;
        check("rst_s_valid", s_wv, 1'b0);
        check("rst_s_done", s_fd, 1'b0);
        check("rst_s_win", s_win, '0);
        check("rst_b_valid", b_wv, 1'b0);
        check("rst_b_win", b_win, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, first and last windows pinned to literal values
        add_frame(0, 1'b0);
        tbl[10].ew = mk9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        tbl[15].ew = mk9(5, 6, 7, 9, 10, 11, 13, 14, 15);
        run_tbl("basic", 4);

        // Same frame with a gap after every pixel
        add_frame(0, 1'b1);
        run_tbl("bubble", 4);

        // Two frames back to back; the second only windows once its own rows fill
        add_frame(0, 1'b0);
        add_frame(100, 1'b0);
        tbl[26].ew = mk9(100, 101, 102, 104, 105, 106, 108, 109, 110);
        run_tbl("b2b", 8);

        // Clear after pixel 6 (pixel presented with clear is dropped), then a fresh frame
        for (int p = 0; p <= 6; p++) add(1'b1, 1'b0, p, 1'b0, 1'b0, '0);
        add(1'b1, 1'b1, 77, 1'b0, 1'b0, '0);
        add_frame(0, 1'b0);
        run_tbl("clear", 4);

        // Async reset mid-row right after a valid window
        for (int p = 0; p <= 10; p++) push_s(1'b1, 1'b0, 16'(p));
        check("pre_rst_valid", s_wv, 1'b1);
        s_pv = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", s_wv, 1'b0);
        check("arst_done", s_fd, 1'b0);
        check("arst_win", s_win, '0);
        @(negedge clk);
        rst_n = 1'b1;
        add_frame(0, 1'b0);
        run_tbl("post_rst", 4);

        // Default 28x28 frame with random pixels against a sliding-window model
        begin
            int nw = 0, nd = 0;
            for (int r = 0; r < 28; r++) begin
                for (int c = 0; c < 28; c++) begin
                    logic ev;
                    @(negedge clk);
                    b_pv = 1'b1;
                    b_pix = 16'($urandom);
                    img[r][c] = b_pix;
                    @(posedge clk);
                    #1;
                    ev = (r >= 2) && (c >= 2);
                    check("big_valid", b_wv, ev);
                    check("big_done", b_fd, (r == 27) && (c == 27));
                    if (ev) begin
                        win_t w;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                w[i*3 + j] = img[r-2+i][c-2+j];
                        check("big_win", b_win, w);
                    end
                    if (b_wv) nw++;
                    if (b_fd) nd++;
                end
            end
            @(negedge clk);
            b_pv = 1'b0;
            check("big_count", nw, 676);
            check("big_done_count", nd, 1);
            @(posedge clk);
            #1;
            check("big_idle_valid", b_wv, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
